uart_mem_reader: RTL and testbench

Sequencer that drains a burst of bytes from the 16×8 register-file memory and presents them one at a time to the UART transmitter over a valid/ready handshake. It sits between the memory read port (driving `addr`/`rd_mem`, consuming `rd_mem_data`) and the TX framer's byte input. A `start` pulse launches a burst of programmable length and start address. Completion is flagged with a one-cycle `done` pulse.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_mem_reader_if.sv | 24 ++
 rtl/uart_mem_reader.sv | 149 ++++++++++++++
 tb/tb_uart_mem_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART memory reader slice.
package uart_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  typedef logic [DATA_W-1:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_CSUM  = 3'd4
  } rd_state_t;

endpackage

// File: rtl/uart_mem_reader_if.sv
// Memory read port plus transmitter byte handshake between the reader and its peers.
interface uart_mem_reader_if #(
  parameter int ADDR_W = uart_pkg::ADDR_W,
  parameter int DATA_W = uart_pkg::DATA_W
);

  logic [ADDR_W-1:0] addr;
  logic              rd_mem;
  logic [DATA_W-1:0] rd_mem_data;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output addr, rd_mem, tx_data, tx_valid,
    input  rd_mem_data, tx_ready
  );

  modport slave (
    input  addr, rd_mem, tx_data, tx_valid,
    output rd_mem_data, tx_ready
  );

endinterface

// File: rtl/uart_mem_reader.sv
// Drains a burst of bytes from the register-file memory into the UART TX handshake.
// Optional trailing XOR checksum byte is built in when UART_MEM_RD_CSUM_EN is defined.
module uart_mem_reader
  import uart_pkg::*;
#(
  parameter int ADDR_W = uart_pkg::ADDR_W,
  parameter int DATA_W = uart_pkg::DATA_W,
  parameter int DEPTH  = uart_pkg::DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W:0]     len,
  output logic                busy,
  output logic                done,
  uart_mem_reader_if.master   bus
);

  localparam logic [ADDR_W:0]   MAX_LEN  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_LEN  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   ZERO_LEN = (ADDR_W+1)'(0);
  localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);

  rd_state_t          state_r;
  logic [ADDR_W-1:0]  ptr_r;
  logic [ADDR_W:0]    remaining_r;
  logic [ADDR_W-1:0]  addr_r;
  logic               rd_mem_r;
  logic [DATA_W-1:0]  tx_data_r;
  logic               tx_valid_r;
  logic               busy_r;
  logic               done_r;

  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] req);
    return (req > MAX_LEN) ? MAX_LEN : req;
  endfunction

`ifdef UART_MEM_RD_CSUM_EN
  logic [DATA_W-1:0] csum_r;

  function automatic logic [DATA_W-1:0] csum_next(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] b);
    return acc ^ b;
  endfunction
`endif

  // Reader FSM; every output is a register so nothing combinational leaves the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {ADDR_W{1'b0}};
      remaining_r <= ZERO_LEN;
      addr_r      <= {ADDR_W{1'b0}};
      rd_mem_r    <= 1'b0;
      tx_data_r   <= {DATA_W{1'b0}};
      tx_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef UART_MEM_RD_CSUM_EN
      csum_r      <= {DATA_W{1'b0}};
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A zero-length request is dropped without raising busy or done.
          if (start && (len != ZERO_LEN)) begin
            ptr_r       <= start_addr;
            addr_r      <= start_addr;
            remaining_r <= clamp_len(len);
            rd_mem_r    <= 1'b1;
            busy_r      <= 1'b1;
`ifdef UART_MEM_RD_CSUM_EN
            csum_r      <= {DATA_W{1'b0}};
`endif
            state_r     <= ST_READ;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_READ: begin
          rd_mem_r <= 1'b0;
          state_r  <= ST_LATCH;
        end
        ST_LATCH: begin
          tx_data_r  <= bus.rd_mem_data;
          tx_valid_r <= 1'b1;
          state_r    <= ST_SEND;
        end
        ST_SEND: begin
          if (bus.tx_ready) begin
            remaining_r <= remaining_r - ONE_LEN;
`ifdef UART_MEM_RD_CSUM_EN
            csum_r      <= csum_next(csum_r, tx_data_r);
`endif
            if (remaining_r == ONE_LEN) begin
`ifdef UART_MEM_RD_CSUM_EN
              // Checksum byte goes out next with tx_valid kept high.
              tx_data_r  <= csum_next(csum_r, tx_data_r);
              tx_valid_r <= 1'b1;
              state_r    <= ST_CSUM;
`else
              tx_valid_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              state_r    <= ST_IDLE;
`endif
            end else begin
              ptr_r      <= ptr_r + ONE_ADDR;
              addr_r     <= ptr_r + ONE_ADDR;
              rd_mem_r   <= 1'b1;
              tx_valid_r <= 1'b0;
              state_r    <= ST_READ;
            end
          end else begin
            state_r <= ST_SEND;
          end
        end
`ifdef UART_MEM_RD_CSUM_EN
        ST_CSUM: begin
          if (bus.tx_ready) begin
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            state_r <= ST_CSUM;
          end
        end
`endif
        default: begin
          rd_mem_r   <= 1'b0;
          tx_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.addr     = addr_r;
  assign bus.rd_mem   = rd_mem_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.tx_valid = tx_valid_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_uart_mem_reader.sv
// Scoreboard bench for uart_mem_reader with a behavioural 16x8 register-file memory.
module tb_uart_mem_reader;
  import uart_pkg::*;

`ifdef UART_MEM_RD_CSUM_EN
  localparam int CSUM_ON = 1;
`else
  localparam int CSUM_ON = 0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] len;
  logic       busy;
  logic       done;

  uart_mem_reader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  uart_mem_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  byte_t mem [16];

  always @(posedge clk) begin
    if (bus.rd_mem) bus.rd_mem_data <= mem[bus.addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  byte_t      exp_q[$];
  byte_t      got_q[$];
  logic [3:0] obs_addr_q[$];
  int   obs_rd, obs_done, obs_first_valid, obs_done_k, obs_last_acc, obs_unstable;
  logic obs_busy_any, obs_busy_at_done, obs_busy_k1;

  // Drives one burst, pushes the expected bytes and records what the DUT does.
  task automatic run_burst(input logic [3:0] sa, input logic [4:0] ln, input int stall,
                           input int budget);
    int n;
    int stall_cnt;
    byte_t cs;
    byte_t held;
    logic held_v;
    logic [3:0] idx;
    exp_q.delete(); got_q.delete(); obs_addr_q.delete();
    obs_rd = 0; obs_done = 0; obs_first_valid = -1; obs_done_k = -1; obs_last_acc = -1;
    obs_unstable = 0; obs_busy_any = 1'b0; obs_busy_at_done = 1'b1; obs_busy_k1 = 1'b0;
    n = (ln > 5'd16) ? 16 : int'(ln);
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      idx = sa + 4'(i);
      exp_q.push_back(mem[idx]);
      cs = cs ^ mem[idx];
    end
    if (CSUM_ON == 1 && n > 0) exp_q.push_back(cs);
    stall_cnt = 0;
    held = 8'h00;
    held_v = 1'b0;
    @(negedge clk);
    start = 1'b1; start_addr = sa; len = ln; bus.tx_ready = (stall == 0);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      if (k == 1) obs_busy_k1 = busy;
      obs_busy_any = obs_busy_any | busy;
      if (bus.rd_mem) begin
        obs_rd++;
        obs_addr_q.push_back(bus.addr);
      end
      if (done) begin
        obs_done++;
        obs_done_k = k;
        obs_busy_at_done = busy;
      end
      if (bus.tx_valid) begin
        if (obs_first_valid < 0) obs_first_valid = k;
        if (held_v && bus.tx_data !== held) obs_unstable++;
        held = bus.tx_data;
        held_v = 1'b1;
        if (stall_cnt < stall) begin
          bus.tx_ready = 1'b0;
          stall_cnt++;
        end else begin
          bus.tx_ready = 1'b1;
          got_q.push_back(bus.tx_data);
          obs_last_acc = k;
          stall_cnt = 0;
          held_v = 1'b0;
        end
      end else begin
        bus.tx_ready = (stall == 0);
      end
      if (obs_done_k >= 0 && k >= obs_done_k + 2) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.addr, bus.rd_mem, bus.tx_data, bus.tx_valid, busy, done} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0000",
               {bus.addr, bus.rd_mem, bus.tx_data, bus.tx_valid, busy, done});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, bus.rd_mem, bus.tx_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_after_reset: got %b want 0000", {busy, done, bus.rd_mem, bus.tx_valid});
    end
  endtask

  task automatic test_basic();
    int want_last;
    byte_t e, g;
    run_burst(4'd0, 5'd4, 0, 100);
    want_last = 3 * 4 + CSUM_ON;
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL basic_byte: got %h want %h", g, e); end
    end
    total++;
    if (obs_busy_k1 !== 1'b1) begin bad++; $display("FAIL basic_busy_rise: got %b want 1", obs_busy_k1); end
    total++;
    if (obs_first_valid !== 3) begin bad++; $display("FAIL basic_first_valid: got %0d want 3", obs_first_valid); end
    total++;
    if (obs_last_acc !== want_last) begin bad++; $display("FAIL basic_last_accept: got %0d want %0d", obs_last_acc, want_last); end
    total++;
    if (obs_done !== 1 || obs_done_k !== want_last + 1) begin
      bad++; $display("FAIL basic_done: got count %0d at %0d want 1 at %0d", obs_done, obs_done_k, want_last + 1);
    end
    total++;
    if (obs_busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy_fall: got %b want 0", obs_busy_at_done); end
    total++;
    if (obs_rd !== 4) begin bad++; $display("FAIL basic_rd_count: got %0d want 4", obs_rd); end
  endtask

  task automatic test_backpressure();
    byte_t e, g;
    run_burst(4'd0, 5'd4, 5, 400);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL bp_byte: got %h want %h", g, e); end
    end
    total++;
    if (obs_unstable !== 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", obs_unstable); end
    total++;
    if (obs_rd !== 4) begin bad++; $display("FAIL bp_rd_count: got %0d want 4", obs_rd); end
    total++;
    if (obs_done !== 1) begin bad++; $display("FAIL bp_done: got %0d want 1", obs_done); end
  endtask

  task automatic test_wrap();
    logic [3:0] want_addr [4];
    byte_t e, g;
    want_addr[0] = 4'd14; want_addr[1] = 4'd15; want_addr[2] = 4'd0; want_addr[3] = 4'd1;
    run_burst(4'd14, 5'd4, 0, 100);
    total++;
    if (obs_addr_q.size() !== 4) begin bad++; $display("FAIL wrap_addr_count: got %0d want 4", obs_addr_q.size()); end
    for (int i = 0; i < 4 && i < obs_addr_q.size(); i++) begin
      total++;
      if (obs_addr_q[i] !== want_addr[i]) begin
        bad++; $display("FAIL wrap_addr: got %0d want %0d", obs_addr_q[i], want_addr[i]);
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL wrap_byte: got %h want %h", g, e); end
    end
  endtask

  task automatic test_len_zero();
    run_burst(4'd3, 5'd0, 0, 12);
    total++;
    if (obs_busy_any !== 1'b0) begin bad++; $display("FAIL len0_busy: got %b want 0", obs_busy_any); end
    total++;
    if (obs_done !== 0 || obs_rd !== 0) begin
      bad++; $display("FAIL len0_activity: got done %0d rd %0d want 0 0", obs_done, obs_rd);
    end
  endtask

  task automatic test_clamp();
    byte_t e, g;
    run_burst(4'd5, 5'd20, 0, 200);
    total++;
    if (got_q.size() !== 16 + CSUM_ON) begin
      bad++; $display("FAIL clamp_count: got %0d want %0d", got_q.size(), 16 + CSUM_ON);
    end
    total++;
    if (obs_rd !== 16) begin bad++; $display("FAIL clamp_rd_count: got %0d want 16", obs_rd); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL clamp_byte: got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    int dones;
    byte_t e, g;
    acc = 0;
    @(negedge clk);
    start = 1'b1; start_addr = 4'd0; len = 5'd4; bus.tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && acc < 2; k++) begin
      if (bus.tx_valid) acc++;
      @(negedge clk);
    end
    total++;
    if (acc !== 2) begin bad++; $display("FAIL rstmid_accepts: got %0d want 2", acc); end
    rst = 1'b1;
    #1;
    total++;
    if ({bus.addr, bus.rd_mem, bus.tx_data, bus.tx_valid, busy, done} !== 16'h0000) begin
      bad++;
      $display("FAIL rstmid_outputs: got %h want 0000",
               {bus.addr, bus.rd_mem, bus.tx_data, bus.tx_valid, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", dones); end
    run_burst(4'd0, 5'd4, 0, 100);
    total++;
    if (got_q.size() !== exp_q.size() || obs_done !== 1) begin
      bad++; $display("FAIL rstmid_rerun: got %0d bytes %0d done want %0d bytes 1 done",
                      got_q.size(), obs_done, exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL rstmid_byte: got %h want %h", g, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    start = 1'b0; start_addr = 4'd0; len = 5'd0; bus.tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h30 + 8'(i * 7));
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_len_zero();
    test_clamp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
